adc_ascii_framer: RTL

Multi-channel successor to the single-byte ASCII converter. On a trigger, it captures CH_NUM ADC samples of DATA_W bits each and converts each to zero-padded decimal ASCII. It streams the result as a comma-separated, CR/LF-terminated line through the start/done handshake of the existing `uart_tx`. It sits between the SPI ADC readout/controller and `uart_tx`.

---
 rtl/adc_ascii_framer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adc_ascii_framer.sv
// adc_ascii_framer: captures CH_NUM ADC samples and streams them to uart_tx as a CSV ASCII line ending in CR/LF.
// Define REPORT_CHECKSUM_EN to insert "*HH" (XOR of the preceding frame bytes) before CR/LF.
module adc_ascii_framer #(
   parameter int         CH_NUM = 4,
   parameter int         DATA_W = 8,
   parameter int         NDIG   = 3,
   parameter logic [7:0] SEP    = 8'h2C
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       trig,
   input  logic [CH_NUM*DATA_W-1:0]   ch_data,
   input  logic                       tx_done,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       overrun
);
   localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = NDIG * 4;

   typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT, NEXT} state_t;
   typedef enum logic [2:0] {SEL_DIG, SEL_SEP, SEL_STAR, SEL_HX_HI, SEL_HX_LO, SEL_CR, SEL_LF} sel_t;

`ifdef REPORT_CHECKSUM_EN
   localparam sel_t SEL_TAIL = SEL_STAR;
`else
   localparam sel_t SEL_TAIL = SEL_CR;
`endif

   state_t                   state;
   sel_t                     sel;
   logic [CH_W-1:0]          ch;
   logic [DIG_W-1:0]         dig_idx;
   logic [CNT_W-1:0]         cnt;
   logic [CH_NUM*DATA_W-1:0] cap;
   logic [DATA_W-1:0]        sh;
   logic [DATA_W-1:0]        nxt_sample;
   logic [BCD_W-1:0]         bcd;
   logic [7:0]               byte_sel;

   // One double-dabble iteration: +3 on every digit >= 5, then shift in the next sample bit.
   function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd_in,
                                                     input logic             in_bit);
      logic [BCD_W-1:0] adj;
      adj = bcd_in;
      for (int d = 0; d < NDIG; d++) begin
         if (adj[d*4 +: 4] >= 4'd5)
            adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
      return {adj[BCD_W-2:0], in_bit};
   endfunction

`ifdef REPORT_CHECKSUM_EN
   logic [7:0] csum;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction
`endif

   assign overrun = trig & busy;

   always_comb begin
      nxt_sample = cap[((int'(ch) + 1) % CH_NUM) * DATA_W +: DATA_W];
   end

   always_comb begin
      byte_sel = 8'h00;
      case (sel)
         SEL_DIG:   byte_sel = 8'h30 + {4'h0, bcd[int'(dig_idx)*4 +: 4]};
         SEL_SEP:   byte_sel = SEP;
`ifdef REPORT_CHECKSUM_EN
         SEL_STAR:  byte_sel = 8'h2A;
         SEL_HX_HI: byte_sel = hex_ascii(csum[7:4]);
         SEL_HX_LO: byte_sel = hex_ascii(csum[3:0]);
`endif
         SEL_CR:    byte_sel = 8'h0D;
         SEL_LF:    byte_sel = 8'h0A;
         default:   byte_sel = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         sel        <= SEL_DIG;
         ch         <= '0;
         dig_idx    <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  ch    <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  sel     <= SEL_DIG;
                  dig_idx <= DIG_W'(NDIG - 1);
                  state   <= SEND;
               end
            end
            SEND: begin
               tx_data  <= byte_sel;
               tx_start <= 1'b1;
               state    <= WAIT;
            end
            WAIT: begin
               if (tx_done)
                  state <= NEXT;
            end
            NEXT: begin
               state <= SEND;
               case (sel)
                  SEL_DIG: begin
                     if (dig_idx != '0)
                        dig_idx <= dig_idx - 1'b1;
                     else if (ch != CH_W'(CH_NUM - 1))
                        sel <= SEL_SEP;
                     else
                        sel <= SEL_TAIL;
                  end
                  SEL_SEP: begin
                     ch    <= ch + 1'b1;
                     cnt   <= '0;
                     state <= CONV;
                  end
                  SEL_STAR:  sel <= SEL_HX_HI;
                  SEL_HX_HI: sel <= SEL_HX_LO;
                  SEL_HX_LO: sel <= SEL_CR;
                  SEL_CR:    sel <= SEL_LF;
                  default: begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sample capture and BCD conversion datapath; sequenced by the FSM, not reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && trig) begin
         cap <= ch_data;
         sh  <= ch_data[DATA_W-1:0];
         bcd <= '0;
      end else if (state == CONV) begin
         bcd <= dabble_step(bcd, sh[DATA_W-1]);
         sh  <= sh << 1;
      end else if (state == NEXT && sel == SEL_SEP) begin
         sh  <= nxt_sample;
         bcd <= '0;
      end
   end

`ifdef REPORT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (state == IDLE && trig)
         csum <= '0;
      else if (state == SEND && (sel == SEL_DIG || sel == SEL_SEP))
         csum <= csum ^ byte_sel;
   end
`endif

endmodule
